// File: rtl/buffer_ramt_qsize_reader_pkg.sv
// Shared constants and types for the buffer-RAM QSIZE reader: word width,
// RAM read latency, control/stream field groupings and the reader FSM state.
package buffer_ramt_qsize_reader_pkg;

    localparam int QSIZE               = 32;
    localparam int BUFFER_READ_LATENCY = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } reader_state_e;

    // Fixed-width control and stream inputs; base/len widths depend on DEPTH
    // and therefore travel on the interface directly.
    typedef struct packed {
        logic             start;
        logic             out_ready;
        logic [QSIZE-1:0] ram_rdata;
    } BufferRAMTQsizeReaderInputs;

    typedef struct packed {
        logic             busy;
        logic             done;
        logic             ram_ren;
        logic             out_valid;
        logic             out_last;
        logic [QSIZE-1:0] out_data;
    } BufferRAMTQsizeReaderOutputs;

endpackage

// File: rtl/buffer_ramt_qsize_reader_if.sv
// Signal bundle between the reader, its control master, the buffer RAM read
// port and the downstream stream sink.
interface buffer_ramt_qsize_reader_if
    import buffer_ramt_qsize_reader_pkg::*;
#(
    parameter int DEPTHAD = 9,
    parameter int LENW    = DEPTHAD + 1
) ();

    logic                start;
    logic [DEPTHAD-1:0]  base;
    logic [LENW-1:0]     len;
    logic                busy;
    logic                done;

    logic [DEPTHAD-1:0]  ram_raddr;
    logic                ram_ren;
    logic [QSIZE-1:0]    ram_rdata;

    // Stream: a word transfers on every rising edge where out_valid and
    // out_ready are both high; once out_valid rises, out_data/out_last hold
    // until that transfer, and out_valid never depends on out_ready.
    logic [QSIZE-1:0]    out_data;
    logic                out_valid;
    logic                out_last;
    logic                out_ready;

    reader_state_e       dbg_state;

    modport slave (
        input  start, base, len, ram_rdata, out_ready,
        output busy, done, ram_raddr, ram_ren, out_data, out_valid, out_last,
               dbg_state
    );

    modport master (
        output start, base, len, ram_rdata, out_ready,
        input  busy, done, ram_raddr, ram_ren, out_data, out_valid, out_last,
               dbg_state
    );

endinterface

// File: rtl/buffer_ramt_qsize_reader_qsize_sync_fifo.sv
// Synchronous FIFO with occupancy count; push and pop may share a cycle,
// including push into a full FIFO while it is being popped.
module buffer_ramt_qsize_reader_qsize_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: the count masks every unwritten entry.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/buffer_ramt_qsize_reader.sv
// Streams a wrap-around range of words out of a fixed-latency buffer RAM,
// matching returning data to issued reads and absorbing backpressure in a FIFO.
module buffer_ramt_qsize_reader
    import buffer_ramt_qsize_reader_pkg::*;
#(
    parameter int DEPTH        = 512,
    parameter int DEPTHAD      = $clog2(DEPTH),
    parameter int READ_LATENCY = BUFFER_READ_LATENCY,
    parameter int FIFO_DEPTH   = READ_LATENCY + 2,
    parameter int LENW         = DEPTHAD + 1
) (
    input logic                        clk,
    input logic                        rstn,
    buffer_ramt_qsize_reader_if.slave  bus
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    BufferRAMTQsizeReaderInputs  in_s;
    BufferRAMTQsizeReaderOutputs out_s;

    reader_state_e          state_q, state_d;
    logic [DEPTHAD-1:0]     addr_q, addr_d;
    logic [LENW-1:0]        remaining_q, remaining_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic [READ_LATENCY-1:0] vld_q, last_q;

    logic                   issue, issue_last, credit_ok;
    logic [CW-1:0]          inflight;
    logic [CW-1:0]          fifo_count;
    logic [QSIZE:0]         fifo_dout;
    logic                   fifo_empty, fifo_valid, fifo_last, pop;

    assign in_s = '{start:     bus.start,
                    out_ready: bus.out_ready,
                    ram_rdata: bus.ram_rdata};

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CW'(vld_q[i]);
        end
    end

    // Every outstanding read owns a FIFO slot, so the FIFO can never overflow.
    assign credit_ok  = ({1'b0, inflight} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH);
    assign fifo_valid = !fifo_empty;
    assign fifo_last  = fifo_dout[QSIZE];
    assign pop        = fifo_valid && in_s.out_ready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        issue       = 1'b0;
        issue_last  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_s.start) begin
                    if (bus.len != '0) begin
                        state_d     = ST_RUN;
                        addr_d      = bus.base;
                        remaining_d = bus.len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if ((remaining_q != '0) && credit_ok) begin
                    issue       = 1'b1;
                    issue_last  = (remaining_q == LENW'(1));
                    addr_d      = (addr_q == DEPTHAD'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (issue_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && fifo_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // busy also covers the done cycle of a real transfer.
        busy_d = (state_d != ST_IDLE) || ((state_q == ST_DRAIN) && (state_d == ST_IDLE));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            vld_q       <= '0;
            last_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            vld_q[0]    <= issue;
            last_q[0]   <= issue_last;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i]  <= vld_q[i-1];
                last_q[i] <= last_q[i-1];
            end
        end
    end

    buffer_ramt_qsize_reader_qsize_sync_fifo #(
        .WIDTH (QSIZE + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rstn),
        .push_i  (vld_q[READ_LATENCY-1]),
        .din_i   ({last_q[READ_LATENCY-1], in_s.ram_rdata}),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Stream outputs read zero while empty so reset and idle look identical.
    always_comb begin
        out_s           = '0;
        out_s.busy      = busy_q;
        out_s.done      = done_q;
        out_s.ram_ren   = issue;
        out_s.out_valid = fifo_valid;
        out_s.out_last  = fifo_valid && fifo_last;
        out_s.out_data  = fifo_valid ? fifo_dout[QSIZE-1:0] : '0;
    end

    assign bus.busy      = out_s.busy;
    assign bus.done      = out_s.done;
    assign bus.ram_ren   = out_s.ram_ren;
    assign bus.ram_raddr = addr_q;
    assign bus.out_valid = out_s.out_valid;
    assign bus.out_last  = out_s.out_last;
    assign bus.out_data  = out_s.out_data;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_buffer_ramt_qsize_reader.sv
// Directed bench for the buffer-RAM QSIZE reader with a latency-matched RAM
// model (mem[a] = a) on a 20-word, non-power-of-two buffer.
module tb_buffer_ramt_qsize_reader;
    import buffer_ramt_qsize_reader_pkg::*;

    localparam int DEPTH = 20;
    localparam int DAW   = $clog2(DEPTH);
    localparam int LW    = DAW + 1;
    localparam int RL    = BUFFER_READ_LATENCY;
    localparam int FD    = RL + 2;
    localparam int W     = QSIZE + 1;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    buffer_ramt_qsize_reader_if #(.DEPTHAD(DAW), .LENW(LW)) bus ();

    buffer_ramt_qsize_reader #(
        .DEPTH        (DEPTH),
        .DEPTHAD      (DAW),
        .READ_LATENCY (RL),
        .FIFO_DEPTH   (FD),
        .LENW         (LW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [QSIZE-1:0] mem   [DEPTH];
    logic [QSIZE-1:0] rpipe [RL];

    always @(posedge clk) begin
        rpipe[0] <= mem[bus.ram_raddr];
        for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
    end
    assign bus.ram_rdata = rpipe[RL-1];

    logic [W-1:0] exp_q[$];
    int tests = 0, fails = 0;
    int cyc = 0, c0 = 0;
    int ren_cnt = 0, done_cnt = 0, pop_cnt = 0, outstanding = 0;
    int first_valid_cyc = -1, last_pop_cyc = -1, done_cyc = -1;
    int p0, r0, d0, k;
    logic         busy_at_done = 1'b0;
    logic         held = 1'b0;
    logic [W-1:0] held_word = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_range(input int base, input int len);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({(i == len - 1), QSIZE'((base + i) % DEPTH)});
        end
    endtask

    // Observe at the falling edge what the next rising edge will do, then
    // return 1 time unit after that rising edge.
    task automatic step();
        logic [W-1:0] e;
        @(negedge clk);
        cyc++;
        if (rstn) begin
            if (held) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_word", {bus.out_last, bus.out_data}, held_word);
            end
            if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.out_valid && bus.out_ready) begin
                check("word_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("word", {bus.out_last, bus.out_data}, e);
                end
                pop_cnt++;
                last_pop_cyc = cyc;
            end
            held      = bus.out_valid && !bus.out_ready;
            held_word = {bus.out_last, bus.out_data};
            if (bus.done) begin
                done_cnt++;
                done_cyc     = cyc;
                busy_at_done = bus.busy;
                check("done_not_with_last", (bus.out_valid && bus.out_last), 0);
            end
            if (bus.ram_ren) ren_cnt++;
            outstanding += int'(bus.ram_ren) - int'(bus.out_valid && bus.out_ready);
            if (bus.ram_ren) check("credit", (outstanding <= FD), 1);
        end else begin
            held        = 1'b0;
            outstanding = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input int base, input int len);
        bus.start       = 1'b1;
        bus.base        = DAW'(base);
        bus.len         = LW'(len);
        first_valid_cyc = -1;
        step();
        c0        = cyc;
        bus.start = 1'b0;
    endtask

    task automatic run_until_done(input int budget, input int mode);
        int n  = 0;
        int dd = done_cnt;
        while (done_cnt == dd && n < budget) begin
            if (mode == 1) bus.out_ready = (n >= 6 && n < 26) ? 1'b0 : 1'($urandom_range(0, 1));
            step();
            n++;
        end
        check("done_timeout", (done_cnt != dd), 1);
        bus.out_ready = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  bus.busy, 0);
        check({tag, "_done"},  bus.done, 0);
        check({tag, "_raddr"}, bus.ram_raddr, 0);
        check({tag, "_ren"},   bus.ram_ren, 0);
        check({tag, "_valid"}, bus.out_valid, 0);
        check({tag, "_last"},  bus.out_last, 0);
        check({tag, "_data"},  bus.out_data, 0);
        check({tag, "_state"}, bus.dbg_state, ST_IDLE);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < DEPTH; a++) mem[a] = QSIZE'(a);
        bus.start     = 1'b0;
        bus.base      = '0;
        bus.len       = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) step();
        check_reset_outputs("reset");
        rstn = 1'b1;
        step();

        // Basic transfer: 10..13, first valid at cycle 2+RL, done one cycle after last pop
        p0 = pop_cnt;
        expect_range(10, 4);
        start_xfer(10, 4);
        check("t1_busy_c1", bus.busy, 1);
        check("t1_ren_c1", bus.ram_ren, 1);
        check("t1_raddr_c1", bus.ram_raddr, 10);
        check("t1_state_c1", bus.dbg_state, ST_RUN);
        run_until_done(40, 0);
        check("t1_first_valid", first_valid_cyc, c0 + 2 + RL);
        check("t1_no_bubbles", last_pop_cyc - first_valid_cyc, 3);
        check("t1_done_lag", done_cyc, last_pop_cyc + 1);
        check("t1_busy_at_done", busy_at_done, 1);
        check("t1_busy_after", bus.busy, 0);
        check("t1_pops", pop_cnt - p0, 4);
        check("t1_sb_empty", exp_q.size(), 0);

        // Wrap at DEPTH with a start pulse during RUN that must be ignored
        p0 = pop_cnt;
        r0 = ren_cnt;
        expect_range(DEPTH - 2, 4);
        start_xfer(DEPTH - 2, 4);
        step();
        bus.start = 1'b1;
        bus.base  = DAW'(3);
        bus.len   = LW'(2);
        step();
        bus.start = 1'b0;
        run_until_done(40, 0);
        repeat (5) step();
        check("t2_pops", pop_cnt - p0, 4);
        check("t2_reads", ren_cnt - r0, 4);
        check("t2_sb_empty", exp_q.size(), 0);
        check("t2_idle_valid", bus.out_valid, 0);
        check("t2_idle_state", bus.dbg_state, ST_IDLE);

        // Backpressure: random out_ready with a 20-cycle low hold
        p0 = pop_cnt;
        r0 = ren_cnt;
        expect_range(5, 16);
        start_xfer(5, 16);
        run_until_done(400, 1);
        check("t3_pops", pop_cnt - p0, 16);
        check("t3_reads", ren_cnt - r0, 16);
        check("t3_sb_empty", exp_q.size(), 0);

        // len = 0: done next cycle, no RAM access, busy stays low
        r0 = ren_cnt;
        d0 = done_cnt;
        start_xfer(4, 0);
        check("t4_busy_c1", bus.busy, 0);
        step();
        check("t4_done_cycle", done_cyc, c0 + 1);
        check("t4_busy_at_done", busy_at_done, 0);
        repeat (3) step();
        check("t4_no_reads", ren_cnt - r0, 0);
        check("t4_single_done", done_cnt - d0, 1);
        check("t4_busy_after", bus.busy, 0);

        // Full-buffer read: last on address base-1
        p0 = pop_cnt;
        expect_range(7, DEPTH);
        start_xfer(7, DEPTH);
        run_until_done(100, 0);
        check("t5_pops", pop_cnt - p0, DEPTH);
        check("t5_no_bubbles", last_pop_cyc - first_valid_cyc, DEPTH - 1);
        check("t5_sb_empty", exp_q.size(), 0);

        // Reset in DRAIN with two words queued, then a clean transfer
        bus.out_ready = 1'b0;
        expect_range(2, 4);
        start_xfer(2, 4);
        k = 0;
        while (bus.dbg_state != ST_DRAIN && k < 20) begin
            step();
            k++;
        end
        check("t6_reach_drain", (bus.dbg_state == ST_DRAIN), 1);
        check("t6_queued", bus.out_valid, 1);
        d0   = done_cnt;
        rstn = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        exp_q.delete();
        repeat (3) step();
        rstn          = 1'b1;
        bus.out_ready = 1'b1;
        repeat (4) step();
        check("t6_no_stale_valid", bus.out_valid, 0);
        check("t6_no_done", done_cnt - d0, 0);
        p0 = pop_cnt;
        expect_range(12, 3);
        start_xfer(12, 3);
        run_until_done(40, 0);
        check("t6_pops", pop_cnt - p0, 3);
        check("t6_sb_empty", exp_q.size(), 0);
        check("t6_one_done", done_cnt - d0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/buffer_ramt_qsize_reader.md
# buffer_ramt_qsize_reader

- Streams a contiguous, wrap-around range of QSIZE words out of a QSIZE-wide buffer RAM that has a fixed read latency.
- Presents the words on a valid/ready stream.
- Sits on the read side of the buffer RAM:
  - drives its read address;
  - aligns the returning read data to the issued requests;
  - absorbs downstream backpressure in a small FIFO, so the RAM needs no read enable or stall.

## Interface

Parameters
- DEPTH, 512: words in the attached RAM.
- DEPTHAD, $clog2(DEPTH): address width.
- READ_LATENCY, BUFFER_READ_LATENCY: cycles from raddr to rdata. Must match the RAM; must be ≥ 1.
- FIFO_DEPTH, READ_LATENCY+2: return FIFO entries.
- LENW, DEPTHAD+1: length field width (0..DEPTH).

Ports
- clk  in  1  clock. All state changes on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  request a transfer. Sampled only in IDLE.
- base  in  DEPTHAD  first word address.
- len  in  LENW  words to read (0..DEPTH).
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse at transfer completion.
- ram_raddr  out  DEPTHAD  read address to the RAM.
- ram_ren  out  1  marks a real read request (observability only).
- ram_rdata  in  QSIZE  RAM read data.
- out_data  out  QSIZE  stream data.
- out_valid  out  1  stream valid.
- out_last  out  1  high on the final word of a transfer.
- out_ready  in  1  stream ready.

## Operation

- States: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 with len≠0 latches base/len and goes to RUN.
  - start=1 with len=0 pulses done next cycle and stays IDLE; no RAM access.
- RUN, issue condition: remaining>0 AND inflight+fifo_count < FIFO_DEPTH.
  - When true: drive ram_raddr=addr with ram_ren=1; then addr=(addr+1) mod DEPTH and remaining−1.
  - After the last issue, go to DRAIN.
- In-flight tracking: READ_LATENCY-stage shift register of valid bits plus a last bit.
  - The stage emerging in a cycle captures ram_rdata into the FIFO together with its last bit.
  - Unmarked cycles' rdata is ignored.
- Credit rule: inflight+fifo_count never exceeds FIFO_DEPTH, so the FIFO can never overflow.
- Stream: out_valid = FIFO non-empty. A word pops when out_valid & out_ready.
- DRAIN → IDLE when the last-tagged word pops. done pulses the following cycle.
- start in RUN/DRAIN is ignored.
- Widths:
  - the address counter wraps at DEPTH (DEPTH may be a non-power-of-two; compare and reset, do not rely on overflow);
  - the remaining counter is LENW bits.

## Timing

- Reset values: state IDLE; busy 0; done 0; ram_raddr 0; ram_ren 0; out_valid 0; out_last 0; out_data 0.
- The FIFO and in-flight pipe are cleared.
- Reset mid-transfer: in-flight data discarded, no done issued.
- Transfer timeline (start accepted at the edge ending cycle 0):
  - cycle 1: first ram_raddr/ram_ren;
  - cycle 1+READ_LATENCY: data returns;
  - cycle 2+READ_LATENCY: out_valid first high (cycle 4 at READ_LATENCY=2).
- Throughput: with out_ready held high, one word per cycle, no bubbles.
- Backpressure:
  - out_ready low stops issue within one cycle once the credit is exhausted;
  - issue resumes the cycle after a pop frees a credit.
- out_data/out_valid/out_last are stable while out_valid & !out_ready.
- Simultaneous FIFO push and pop in one cycle is legal; the count is unchanged.
- done is never coincident with out_valid of the same transfer's last word. It follows that word's pop by exactly one cycle.
- busy is 1 from the cycle after start acceptance through the done cycle inclusive.

## Structure

- Shared package RISA_PKG gains:
  - typedefs BufferRAMTQsizeReaderInputs and BufferRAMTQsizeReaderOutputs, grouping the control and stream fields;
  - a reader state enum.
- QSIZE and BUFFER_READ_LATENCY remain package constants.
- Sub-module qsize_sync_fifo: parameterised WIDTH/DEPTH synchronous FIFO with count, asynchronous active-low reset, push/pop same cycle. Carries {last, data}.
- The in-flight pipe, credit logic and FSM live in the top module.

## Test plan

- base=10, len=4, out_ready=1, RAM preloaded addr=value → out_data 10,11,12,13 on consecutive cycles starting cycle 2+READ_LATENCY; out_last on 13; done one cycle after.
- base=DEPTH−2, len=4 → words from addresses DEPTH−2, DEPTH−1, 0, 1 in order.
- len=16, out_ready toggled by random pattern including a 20-cycle hold low → all 16 words in order, none dropped or duplicated. Check for every cycle:
  - inflight+fifo_count ≤ FIFO_DEPTH;
  - held data stable while !out_ready.
- start with len=0 → done pulse next cycle, ram_ren never asserted, busy stays 0. Also: start pulsed during RUN → ignored, the transfer completes unchanged.
- len=DEPTH full-buffer read → DEPTH words, last on the word from address base−1 mod DEPTH.
- Assert rstn low mid-DRAIN with 2 words queued → outputs at reset values immediately, no done. A new transfer after reset returns correct data with no stale words.
